// File: rtl/mips_lite_pkg.sv
// Shared constants and types for the MIPS-Lite fetch stage.
package mips_lite_pkg;

   localparam logic [5:0]  OPC_HALT   = 6'h11;
   localparam logic [31:0] WORD_BYTES = 32'd4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_HALTED = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic        valid;
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] pc4;
   } if_id_t;

   function automatic logic is_halt(input logic [5:0] opcode);
      return opcode == OPC_HALT;
   endfunction

endpackage

// File: rtl/mips_lite_fetch_buf.sv
// One-entry holding buffer for an instruction response that arrives while decode is stalled.
module mips_lite_fetch_buf (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        drain,
   input  logic        clear,
   input  logic [31:0] load_instr,
   input  logic [31:0] load_pc,
   output logic        valid,
   output logic [31:0] instr,
   output logic [31:0] pc
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid <= 1'b0;
         instr <= '0;
         pc    <= '0;
      end else if (clear) begin
         valid <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         instr <= load_instr;
         pc    <= load_pc;
      end else if (drain) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/mips_lite_fetch_stage.sv
// MIPS-Lite instruction fetch: PC, 1-cycle imem request tracking, IF/ID register, HALT stop.
// Defining MIPS_LITE_FETCH_CNT_EN adds the fetch_count port and counter.
//
// state      | meaning
// ST_IDLE    | first cycle after reset release, no request issued
// ST_RUN     | fetching, one request per unstalled cycle
// ST_HALTED  | HALT reached IF/ID; no more requests until reset
module mips_lite_fetch_stage
   import mips_lite_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic        if_id_valid,
   output logic [31:0] if_id_instr,
   output logic [31:0] if_id_pc,
   output logic [31:0] if_id_pc4,
   output logic        halted
`ifdef MIPS_LITE_FETCH_CNT_EN
   ,
   output logic [31:0] fetch_count
`endif
);

   fetch_state_e state;
   if_id_t       if_id;
   logic [31:0]  pc;
   logic [31:0]  resp_pc;
   logic         inflight;
   logic         kill;

   logic         buf_valid;
   logic [31:0]  buf_instr;
   logic [31:0]  buf_pc;

   logic         redirect_eff;
   logic [31:0]  redirect_tgt;
   logic         req_fire;
   logic         resp_live;
   logic         load_resp;
   logic         load_buf;
   logic         load_if_id;
   logic [31:0]  load_instr;
   logic [31:0]  load_pc;

   // Redirects only matter while fetching; a halted stage waits for reset.
   assign redirect_eff = redirect && (state != ST_HALTED);
   assign redirect_tgt = redirect_pc & ~(WORD_BYTES - 32'd1);

   assign req_fire   = (state == ST_RUN) && !stall && !buf_valid;
   assign resp_live  = inflight && !kill && (state == ST_RUN) && !redirect_eff;
   assign load_resp  = resp_live && !stall;
   assign load_buf   = buf_valid && !stall && !redirect_eff;
   assign load_if_id = load_resp || load_buf;
   assign load_instr = load_buf ? buf_instr : imem_rdata;
   assign load_pc    = load_buf ? buf_pc : resp_pc;

   assign imem_req    = req_fire;
   assign imem_addr   = pc;
   assign if_id_valid = if_id.valid;
   assign if_id_instr = if_id.instr;
   assign if_id_pc    = if_id.pc;
   assign if_id_pc4   = if_id.pc4;

   mips_lite_fetch_buf u_buf (
      .clk        (clk),
      .rst        (reset),
      .load       (resp_live && stall),
      .drain      (load_buf),
      .clear      (redirect_eff),
      .load_instr (imem_rdata),
      .load_pc    (resp_pc),
      .valid      (buf_valid),
      .instr      (buf_instr),
      .pc         (buf_pc)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= ST_IDLE;
         pc       <= RESET_PC;
         resp_pc  <= RESET_PC;
         inflight <= 1'b0;
         kill     <= 1'b0;
         halted   <= 1'b0;
         if_id    <= '0;
      end else begin
         inflight <= req_fire;
         // A request issued in the redirect cycle targets the old path.
         kill     <= req_fire && redirect_eff;
         if (req_fire)
            resp_pc <= pc;

         if (redirect_eff)
            pc <= redirect_tgt;
         else if (req_fire)
            pc <= pc + WORD_BYTES;

         if (redirect_eff) begin
            if_id.valid <= 1'b0;
         end else if (load_if_id) begin
            if_id.valid <= 1'b1;
            if_id.instr <= load_instr;
            if_id.pc    <= load_pc;
            if_id.pc4   <= load_pc + WORD_BYTES;
         end else if (!stall) begin
            if_id.valid <= 1'b0;
         end

         unique case (state)
            ST_IDLE: state <= ST_RUN;
            ST_RUN: begin
               if (load_if_id && is_halt(load_instr[31:26])) begin
                  state  <= ST_HALTED;
                  halted <= 1'b1;
               end
            end
            ST_HALTED: state <= ST_HALTED;
            default:   state <= ST_IDLE;
         endcase
      end
   end

`ifdef MIPS_LITE_FETCH_CNT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         fetch_count <= '0;
      else if (load_if_id)
         fetch_count <= fetch_count + 32'd1;
   end
`endif

endmodule

// File: tb/tb_mips_lite_fetch_stage.sv
// Bench for mips_lite_fetch_stage: directed timing cases plus randomized stall/redirect
// traffic checked against an in-order fetch-stream reference model.
`timescale 1ns/1ps
module tb_mips_lite_fetch_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        if_id_valid;
   logic [31:0] if_id_instr;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_pc4;
   logic        halted;
`ifdef MIPS_LITE_FETCH_CNT_EN
   logic [31:0] fetch_count;
`endif

   logic [31:0] mem [0:63];
   int          n_checks = 0;
   int          n_errors = 0;

   // Stream model: next expected PC in program order, delivery count, halt flag.
   logic [31:0] exp_pc;
   int          n_deliv;
   bit          halt_seen;
   int          bubbles;
   logic        prev_valid;
   logic [31:0] prev_instr;
   logic [31:0] prev_pc;

   always #5 clk = ~clk;

   always @(posedge clk)
      if (imem_req)
         imem_rdata <= mem[imem_addr[7:2]];

   mips_lite_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
      .clk         (clk),
      .reset       (reset),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_rdata  (imem_rdata),
      .if_id_valid (if_id_valid),
      .if_id_instr (if_id_instr),
      .if_id_pc    (if_id_pc),
      .if_id_pc4   (if_id_pc4),
      .halted      (halted)
`ifdef MIPS_LITE_FETCH_CNT_EN
      ,
      .fetch_count (fetch_count)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      if (obs !== expv) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic model_reset();
      exp_pc    = 32'h0;
      n_deliv   = 0;
      halt_seen = 1'b0;
      bubbles   = 0;
   endtask

   task automatic check_reset_vals();
      chk("rst_imem_req", 32'(imem_req), 32'd0);
      chk("rst_imem_addr", imem_addr, 32'h0);
      chk("rst_valid", 32'(if_id_valid), 32'd0);
      chk("rst_instr", if_id_instr, 32'h0);
      chk("rst_pc", if_id_pc, 32'h0);
      chk("rst_pc4", if_id_pc4, 32'h0);
      chk("rst_halted", 32'(halted), 32'd0);
`ifdef MIPS_LITE_FETCH_CNT_EN
      chk("rst_fetch_count", fetch_count, 32'h0);
`endif
   endtask

   task automatic do_reset();
      reset       = 1'b1;
      stall       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      @(negedge clk);
      #1;
      check_reset_vals();
      @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   // One clock: drive inputs after the falling edge, check the outcome just after the rising edge.
   task automatic cycle(input logic st, input logic rd, input logic [31:0] tgt);
      logic [31:0] word;
      stall       = st;
      redirect    = rd;
      redirect_pc = tgt;
      #1;
      if (st)
         chk("req_in_stall", 32'(imem_req), 32'd0);
      if (halt_seen)
         chk("req_after_halt", 32'(imem_req), 32'd0);
      if (imem_req)
         chk("addr_align", imem_addr & 32'h3, 32'h0);
      prev_valid = if_id_valid;
      prev_instr = if_id_instr;
      prev_pc    = if_id_pc;
      @(posedge clk);
      #1;
      if (rd && !halt_seen) begin
         chk("redirect_bubble", 32'(if_id_valid), 32'd0);
         exp_pc  = tgt & 32'hFFFF_FFFC;
         bubbles = 0;
      end else if (st) begin
         chk("stall_hold_valid", 32'(if_id_valid), 32'(prev_valid));
         if (prev_valid) begin
            chk("stall_hold_pc", if_id_pc, prev_pc);
            chk("stall_hold_instr", if_id_instr, prev_instr);
         end
         bubbles = 0;
      end else if (halt_seen) begin
         chk("halt_consumed", 32'(if_id_valid), 32'd0);
      end else if (if_id_valid) begin
         word = mem[exp_pc[7:2]];
         chk("deliver_pc", if_id_pc, exp_pc);
         chk("deliver_instr", if_id_instr, word);
         chk("deliver_pc4", if_id_pc4, exp_pc + 32'd4);
         n_deliv++;
         if (word[31:26] == 6'h11)
            halt_seen = 1'b1;
         exp_pc  = exp_pc + 32'd4;
         bubbles = 0;
      end else begin
         bubbles++;
         if (bubbles > 3) begin
            chk("fetch_progress", 32'(bubbles), 32'd3);
            bubbles = 0;
         end
      end
      chk("halted", 32'(halted), 32'(halt_seen));
`ifdef MIPS_LITE_FETCH_CNT_EN
      chk("fetch_count", fetch_count, 32'(n_deliv));
`endif
      @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not reach the summary");
      $fatal(1, "timeout");
   end

   initial begin
      bit [31:0]   r;
      logic [31:0] saved;

      for (int i = 0; i < 64; i++) begin
         r      = $urandom;
         mem[i] = {6'h08, r[25:8], 8'(i)};
      end

      // Straight-line fetch: first valid at edge 3 after release.
      do_reset();
      for (int k = 1; k <= 6; k++) begin
         cycle(1'b0, 1'b0, 32'h0);
         if (k < 3)
            chk("straight_bubble", 32'(if_id_valid), 32'd0);
         else
            chk("straight_pc", if_id_pc, 32'((k - 3) * 4));
      end

      // Stall 3 cycles with pc=8 in flight: buffered, delivered once.
      do_reset();
      for (int k = 1; k <= 4; k++)
         cycle(1'b0, 1'b0, 32'h0);
      for (int k = 5; k <= 7; k++) begin
         cycle(1'b1, 1'b0, 32'h0);
         chk("stall_held_pc", if_id_pc, 32'h4);
      end
      cycle(1'b0, 1'b0, 32'h0);
      chk("buf_drain_pc", if_id_pc, 32'h8);
      chk("buf_drain_valid", 32'(if_id_valid), 32'd1);
      cycle(1'b0, 1'b0, 32'h0);
      chk("post_drain_bubble", 32'(if_id_valid), 32'd0);
      cycle(1'b0, 1'b0, 32'h0);
      chk("post_drain_pc", if_id_pc, 32'hC);

      // Redirect to 0x40 with pc=12 in flight: two bubbles then 0x40.
      do_reset();
      for (int k = 1; k <= 5; k++)
         cycle(1'b0, 1'b0, 32'h0);
      chk("pre_redirect_pc", if_id_pc, 32'h8);
      cycle(1'b0, 1'b1, 32'h40);
      chk("redir_bubble1", 32'(if_id_valid), 32'd0);
      cycle(1'b0, 1'b0, 32'h0);
      chk("redir_bubble2", 32'(if_id_valid), 32'd0);
      cycle(1'b0, 1'b0, 32'h0);
      chk("redir_target_pc", if_id_pc, 32'h40);
      chk("redir_target_valid", 32'(if_id_valid), 32'd1);
`ifdef MIPS_LITE_FETCH_CNT_EN
      chk("count_with_kill", fetch_count, 32'd4);
`endif

      // PC wrap at the top of the address space, low target bits forced to zero.
      do_reset();
      for (int k = 1; k <= 3; k++)
         cycle(1'b0, 1'b0, 32'h0);
      cycle(1'b0, 1'b1, 32'hFFFF_FFFF);
      cycle(1'b0, 1'b0, 32'h0);
      cycle(1'b0, 1'b0, 32'h0);
      chk("wrap_pc", if_id_pc, 32'hFFFF_FFFC);
      chk("wrap_pc4", if_id_pc4, 32'h0);
      cycle(1'b0, 1'b0, 32'h0);
      chk("wrap_next_pc", if_id_pc, 32'h0);

      // HALT at pc=16: stops fetch, held under stall, redirects ignored.
      saved  = mem[4];
      mem[4] = 32'h4400_0000;
      do_reset();
      for (int k = 1; k <= 6; k++)
         cycle(1'b0, 1'b0, 32'h0);
      chk("pre_halt_flag", 32'(halted), 32'd0);
      cycle(1'b0, 1'b0, 32'h0);
      chk("halt_pc", if_id_pc, 32'h10);
      chk("halt_flag", 32'(halted), 32'd1);
      cycle(1'b1, 1'b1, 32'h80);
      chk("halt_held_valid", 32'(if_id_valid), 32'd1);
      cycle(1'b0, 1'b1, 32'h80);
      chk("halt_cleared", 32'(if_id_valid), 32'd0);
      for (int k = 0; k < 6; k++) begin
         cycle(1'(k % 2), 1'b1, 32'h80);
         chk("halt_sticky", 32'(halted), 32'd1);
      end
      mem[4] = saved;

      // Reset mid-stream with the holding buffer full.
      do_reset();
      for (int k = 1; k <= 4; k++)
         cycle(1'b0, 1'b0, 32'h0);
      cycle(1'b1, 1'b0, 32'h0);
      stall = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      check_reset_vals();
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      for (int k = 1; k <= 4; k++) begin
         cycle(1'b0, 1'b0, 32'h0);
         if (k == 3)
            chk("restart_pc0", if_id_pc, 32'h0);
         if (k == 4)
            chk("restart_pc4", if_id_pc, 32'h4);
      end

      // Randomized stall/redirect traffic.
      do_reset();
      for (int k = 0; k < 3000; k++)
         cycle(($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 5), $urandom_range(0, 255));

      // Random traffic with a HALT planted somewhere in memory.
      mem[37] = 32'h4400_0000;
      do_reset();
      for (int k = 0; k < 500; k++)
         cycle(($urandom_range(0, 99) < 25), ($urandom_range(0, 99) < 4), $urandom_range(0, 255));

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
